vga_stream_timing: RTL and testbench

Parametrised VGA/HDMI output stage. Generates horizontal and vertical sync timing from internal counters, and issues pixel requests a configurable number of cycles ahead of display so that latency in the frame-buffer read path is absorbed. It also produces built-in test patterns. It sits between the frame-buffer read port and the video PHY/DAC, one instance per output.

---
 rtl/vga_stream_timing.sv | 200 ++++++++++++++++++++
 tb/tb_vga_stream_timing.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_timing.sv
// VGA/HDMI timing generator: sync/DE from free-running counters, pixel requests
// issued REQ_LEAD cycles ahead of display, and built-in test patterns.
module vga_stream_timing #(
  parameter int X_BITS   = 12,
  parameter int Y_BITS   = 12,
  parameter int DATA_W   = 16,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_color,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              data_req,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [X_BITS-1:0] posx,
  output logic [Y_BITS-1:0] posy,
  output logic [DATA_W-1:0] vga_out,
  output logic              frame_start,
  output logic              line_start
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  // Stage 0 is aligned with data_req; stage REQ_LEAD with the returning pixel.
  localparam int NST     = REQ_LEAD + 1;
  localparam int BAR_W   = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
  localparam int BAR_END = 8 * (H_ACT / 8);

  localparam logic [X_BITS-1:0] H_LAST  = X_BITS'(H_TOTAL - 1);
  localparam logic [X_BITS-1:0] H_ACT_C = X_BITS'(H_ACT);
  localparam logic [X_BITS-1:0] HS_BEG  = X_BITS'(H_ACT + H_FP);
  localparam logic [X_BITS-1:0] HS_END  = X_BITS'(H_ACT + H_FP + H_SYNC);
  localparam logic [Y_BITS-1:0] V_LAST  = Y_BITS'(V_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_ACT_C = Y_BITS'(V_ACT);
  localparam logic [Y_BITS-1:0] VS_BEG  = Y_BITS'(V_ACT + V_FP);
  localparam logic [Y_BITS-1:0] VS_END  = Y_BITS'(V_ACT + V_FP + V_SYNC);

  logic [X_BITS-1:0] h_cnt_q, h_cnt_d;
  logic [Y_BITS-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]        active_mode_q, mode_cur;
  logic              h_wrap, frame_origin, raw_de, raw_hs, raw_vs;

  logic              pl_de_q   [NST];
  logic              pl_hs_q   [NST];
  logic              pl_vs_q   [NST];
  logic [X_BITS-1:0] pl_x_q    [NST];
  logic [Y_BITS-1:0] pl_y_q    [NST];
  logic [1:0]        pl_mode_q [NST];

  logic              data_req_q, de_q, hs_q, vs_q, frame_start_q, line_start_q;
  logic [X_BITS-1:0] posx_q;
  logic [Y_BITS-1:0] posy_q;
  logic [DATA_W-1:0] vga_q, pix_d, bar_pix;

  logic              lde, lhs, lvs, gx0, gy0;
  logic [X_BITS-1:0] lx;
  logic [Y_BITS-1:0] ly;
  logic [1:0]        lmode;
  logic [2:0]        bar_idx;
  logic              bar_r, bar_g, bar_b;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + X_BITS'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + Y_BITS'(1);
    // A mode written exactly at the frame origin applies to that frame already.
    frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    mode_cur     = frame_origin ? mode : active_mode_q;
    raw_de = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    raw_hs = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    raw_vs = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      active_mode_q <= '0;
      for (int i = 0; i < NST; i++) begin
        pl_de_q[i]   <= 1'b0;
        pl_hs_q[i]   <= 1'b0;
        pl_vs_q[i]   <= 1'b0;
        pl_x_q[i]    <= '0;
        pl_y_q[i]    <= '0;
        pl_mode_q[i] <= '0;
      end
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      active_mode_q <= mode_cur;
      pl_de_q[0]    <= raw_de;
      pl_hs_q[0]    <= raw_hs;
      pl_vs_q[0]    <= raw_vs;
      pl_x_q[0]     <= h_cnt_q;
      pl_y_q[0]     <= v_cnt_q;
      pl_mode_q[0]  <= mode_cur;
      for (int i = 1; i < NST; i++) begin
        pl_de_q[i]   <= pl_de_q[i-1];
        pl_hs_q[i]   <= pl_hs_q[i-1];
        pl_vs_q[i]   <= pl_vs_q[i-1];
        pl_x_q[i]    <= pl_x_q[i-1];
        pl_y_q[i]    <= pl_y_q[i-1];
        pl_mode_q[i] <= pl_mode_q[i-1];
      end
    end
  end

  always_comb begin
    lde   = pl_de_q[NST-1];
    lhs   = pl_hs_q[NST-1];
    lvs   = pl_vs_q[NST-1];
    lx    = pl_x_q[NST-1];
    ly    = pl_y_q[NST-1];
    lmode = pl_mode_q[NST-1];
    // Bars beyond the last full-width bar fall into index 7 (black).
    bar_idx = (int'(lx) >= BAR_END) ? 3'd7 : 3'(int'(lx) / BAR_W);
    bar_r   = ~bar_idx[1];
    bar_g   = ~bar_idx[2];
    bar_b   = ~bar_idx[0];
  end

  if (DATA_W == 24) begin : g_rgb888
    assign bar_pix = {{8{bar_r}}, {8{bar_g}}, {8{bar_b}}};
  end else begin : g_rgb565
    assign bar_pix = {{5{bar_r}}, {6{bar_g}}, {5{bar_b}}};
  end

  if (X_BITS >= 5) begin : g_gx_wide
    assign gx0 = (lx[4:0] == 5'd0);
  end else begin : g_gx_narrow
    assign gx0 = (lx == '0);
  end

  if (Y_BITS >= 5) begin : g_gy_wide
    assign gy0 = (ly[4:0] == 5'd0);
  end else begin : g_gy_narrow
    assign gy0 = (ly == '0);
  end

  always_comb begin
    pix_d = '0;
    if (lde) begin
      case (lmode)
        2'd0:    pix_d = pixel_data;
        2'd1:    pix_d = bar_pix;
        2'd2:    pix_d = fill_color;
        default: pix_d = (gx0 || gy0) ? '1 : '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_req_q    <= 1'b0;
      de_q          <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      posx_q        <= '0;
      posy_q        <= '0;
      vga_q         <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      data_req_q    <= raw_de && (mode_cur == 2'd0);
      de_q          <= lde;
      hs_q          <= lhs ? HS_POL : ~HS_POL;
      vs_q          <= lvs ? VS_POL : ~VS_POL;
      posx_q        <= lde ? lx : '0;
      posy_q        <= lde ? ly : '0;
      vga_q         <= pix_d;
      frame_start_q <= lde && (lx == '0) && (ly == '0);
      line_start_q  <= lde && (lx == '0);
    end
  end

  assign data_req    = data_req_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign posx        = posx_q;
  assign posy        = posy_q;
  assign vga_out     = vga_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_stream_timing.sv
// Directed bench for vga_stream_timing: four instances (default, REQ_LEAD=3,
// reduced-frame, tiny 24-bit) exercised one scenario task at a time.
module tb_vga_stream_timing;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default configuration
  logic        rst_def = 1'b0;
  logic [1:0]  mode_def = 2'd0;
  logic [15:0] fill_def = 16'h0, pix_def = 16'h0;
  logic        dr_def, hs_def, vs_def, de_def, fs_def, ls_def;
  logic [11:0] px_def, py_def;
  logic [15:0] vo_def;

  // REQ_LEAD = 3
  logic        rst_l3 = 1'b0;
  logic [1:0]  mode_l3 = 2'd0;
  logic [15:0] fill_l3 = 16'h0, pix_l3 = 16'h0;
  logic        dr_l3, hs_l3, vs_l3, de_l3, fs_l3, ls_l3;
  logic [11:0] px_l3, py_l3;
  logic [15:0] vo_l3;

  // reduced frame: H 64/4/8/4 (80), V 16/2/2/2 (22)
  logic        rst_med = 1'b0;
  logic [1:0]  mode_med = 2'd0;
  logic [15:0] fill_med = 16'hF800, pix_med = 16'h1234;
  logic        dr_med, hs_med, vs_med, de_med, fs_med, ls_med;
  logic [11:0] px_med, py_med;
  logic [15:0] vo_med;

  // tiny 24-bit: H 8/2/2/2 (14), V 4/1/1/1 (7)
  logic        rst_sml = 1'b0;
  logic [1:0]  mode_sml = 2'd3;
  logic [23:0] fill_sml = 24'h0, pix_sml = 24'h0;
  logic        dr_sml, hs_sml, vs_sml, de_sml, fs_sml, ls_sml;
  logic [3:0]  px_sml, py_sml;
  logic [23:0] vo_sml;

  vga_stream_timing u_def (
    .clk(clk), .rst_n(rst_def), .mode(mode_def), .fill_color(fill_def), .pixel_data(pix_def),
    .data_req(dr_def), .hsync(hs_def), .vsync(vs_def), .de(de_def), .posx(px_def), .posy(py_def),
    .vga_out(vo_def), .frame_start(fs_def), .line_start(ls_def));

  vga_stream_timing #(.REQ_LEAD(3)) u_l3 (
    .clk(clk), .rst_n(rst_l3), .mode(mode_l3), .fill_color(fill_l3), .pixel_data(pix_l3),
    .data_req(dr_l3), .hsync(hs_l3), .vsync(vs_l3), .de(de_l3), .posx(px_l3), .posy(py_l3),
    .vga_out(vo_l3), .frame_start(fs_l3), .line_start(ls_l3));

  vga_stream_timing #(.H_ACT(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                      .V_ACT(16), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_med (
    .clk(clk), .rst_n(rst_med), .mode(mode_med), .fill_color(fill_med), .pixel_data(pix_med),
    .data_req(dr_med), .hsync(hs_med), .vsync(vs_med), .de(de_med), .posx(px_med), .posy(py_med),
    .vga_out(vo_med), .frame_start(fs_med), .line_start(ls_med));

  vga_stream_timing #(.X_BITS(4), .Y_BITS(4), .DATA_W(24),
                      .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                      .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_sml (
    .clk(clk), .rst_n(rst_sml), .mode(mode_sml), .fill_color(fill_sml), .pixel_data(pix_sml),
    .data_req(dr_sml), .hsync(hs_sml), .vsync(vs_sml), .de(de_sml), .posx(px_sml), .posy(py_sml),
    .vga_out(vo_sml), .frame_start(fs_sml), .line_start(ls_sml));

  // Frame-buffer model for u_l3: answers each request with {y,x} three cycles later.
  logic [15:0] hist [0:3];
  int rx, ry;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_l3) begin
        for (int i = 0; i < 4; i++) hist[i] = 16'h0;
        rx = 0; ry = 0; pix_l3 = 16'h0;
      end else begin
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = dr_l3 ? {ry[7:0], rx[7:0]} : 16'h0;
        if (dr_l3) begin
          rx++;
          if (rx == 640) begin rx = 0; ry = (ry == 479) ? 0 : ry + 1; end
        end
        pix_l3 = hist[3];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [45:0] g46;
    logic [37:0] g38;
    repeat (3) tick();
    g46 = {dr_def, hs_def, vs_def, de_def, px_def, py_def, vo_def, fs_def, ls_def};
    total++;
    if (g46 !== {4'b0110, 42'd0}) begin bad++; $display("FAIL reset_def: got %h want %h", g46, {4'b0110, 42'd0}); end
    g46 = {dr_l3, hs_l3, vs_l3, de_l3, px_l3, py_l3, vo_l3, fs_l3, ls_l3};
    total++;
    if (g46 !== {4'b0110, 42'd0}) begin bad++; $display("FAIL reset_l3: got %h want %h", g46, {4'b0110, 42'd0}); end
    g46 = {dr_med, hs_med, vs_med, de_med, px_med, py_med, vo_med, fs_med, ls_med};
    total++;
    if (g46 !== {4'b0110, 42'd0}) begin bad++; $display("FAIL reset_med: got %h want %h", g46, {4'b0110, 42'd0}); end
    g38 = {dr_sml, hs_sml, vs_sml, de_sml, px_sml, py_sml, vo_sml, fs_sml, ls_sml};
    total++;
    if (g38 !== {4'b0110, 34'd0}) begin bad++; $display("FAIL reset_sml: got %h want %h", g38, {4'b0110, 34'd0}); end
  endtask

  task automatic test_line_timing();
    int dr_r[$], dr_f[$], de_r[$], de_f[$], hs_f[$], hs_r[$];
    logic p_dr = 1'b0, p_de = 1'b0, p_hs = 1'b1;
    int vo_err = 0;
    mode_def = 2'd0; pix_def = 16'hA5C3; rst_def = 1'b1;
    for (int k = 0; k < 1700; k++) begin
      tick();
      if (k == 0) begin
        total++;
        if (dr_def !== 1'b1) begin bad++; $display("FAIL startup_req: got %b want 1", dr_def); end
      end
      if (dr_def && !p_dr) dr_r.push_back(k);
      if (!dr_def && p_dr) dr_f.push_back(k);
      if (de_def && !p_de) de_r.push_back(k);
      if (!de_def && p_de) de_f.push_back(k);
      if (!hs_def && p_hs) hs_f.push_back(k);
      if (hs_def && !p_hs) hs_r.push_back(k);
      if (vo_def !== (de_def ? 16'hA5C3 : 16'h0)) vo_err++;
      p_dr = dr_def; p_de = de_def; p_hs = hs_def;
    end
    total++;
    if (dr_r.size() < 1 || dr_f.size() < 1 || de_r.size() < 2 || de_f.size() < 1 ||
        hs_f.size() < 2 || hs_r.size() < 1) begin
      bad++; $display("FAIL line_edges: got de_rises=%0d hs_falls=%0d want >=2", de_r.size(), hs_f.size());
    end else begin
      total++;
      if (de_r[0] - dr_r[0] !== 3) begin bad++; $display("FAIL req_to_de: got %0d want 3", de_r[0] - dr_r[0]); end
      total++;
      if (de_f[0] - de_r[0] !== 640) begin bad++; $display("FAIL de_width: got %0d want 640", de_f[0] - de_r[0]); end
      total++;
      if (dr_f[0] - dr_r[0] !== 640) begin bad++; $display("FAIL req_width: got %0d want 640", dr_f[0] - dr_r[0]); end
      total++;
      if (de_r[1] - de_r[0] !== 800) begin bad++; $display("FAIL line_period: got %0d want 800", de_r[1] - de_r[0]); end
      total++;
      if (hs_f[1] - hs_f[0] !== 800) begin bad++; $display("FAIL hs_period: got %0d want 800", hs_f[1] - hs_f[0]); end
      total++;
      if (hs_f[0] - de_r[0] !== 656) begin bad++; $display("FAIL hs_offset: got %0d want 656", hs_f[0] - de_r[0]); end
      total++;
      if (hs_r[0] - hs_f[0] !== 96) begin bad++; $display("FAIL hs_width: got %0d want 96", hs_r[0] - hs_f[0]); end
    end
    total++;
    if (vo_err !== 0) begin bad++; $display("FAIL pass_through: got %0d bad cycles want 0", vo_err); end
  endtask

  task automatic test_req_lead3();
    int ex = 0, ey = 0, n_de = 0, shown = 0, dr_at = -1, de_at = -1;
    rst_l3 = 1'b1;
    for (int k = 0; k < 1700; k++) begin
      tick();
      if (dr_l3 && dr_at < 0) dr_at = k;
      if (de_l3) begin
        if (de_at < 0) de_at = k;
        n_de++;
        total++;
        if (px_l3 !== ex[11:0] || py_l3 !== ey[11:0] || vo_l3 !== {ey[7:0], ex[7:0]}) begin
          bad++;
          if (shown < 5) $display("FAIL lead3_pixel: got x=%0d y=%0d out=%h want x=%0d y=%0d out=%h",
                                  px_l3, py_l3, vo_l3, ex, ey, {ey[7:0], ex[7:0]});
          shown++;
        end
        ex++;
        if (ex == 640) begin ex = 0; ey++; end
      end
    end
    total++;
    if (dr_at < 0 || de_at - dr_at !== 4) begin bad++; $display("FAIL lead3_latency: got %0d want 4", de_at - dr_at); end
    total++;
    if (n_de !== 1376) begin bad++; $display("FAIL lead3_de_count: got %0d want 1376", n_de); end
  endtask

  task automatic test_color_bars();
    int pos [6] = '{0, 79, 80, 160, 480, 639};
    logic [15:0] exp_c [6] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h07FF, 16'h001F, 16'h0000};
    int ex = 0;
    logic dr_seen = 1'b0;
    rst_def = 1'b0; mode_def = 2'd1;
    tick(); tick();
    rst_def = 1'b1;
    for (int k = 0; k < 900; k++) begin
      tick();
      if (dr_def) dr_seen = 1'b1;
      if (de_def && ex < 640) begin
        for (int j = 0; j < 6; j++) begin
          if (ex == pos[j]) begin
            total++;
            if (vo_def !== exp_c[j] || px_def !== ex[11:0]) begin
              bad++; $display("FAIL bars_x%0d: got x=%0d out=%h want out=%h", pos[j], px_def, vo_def, exp_c[j]);
            end
          end
        end
        ex++;
      end
    end
    total++;
    if (dr_seen !== 1'b0) begin bad++; $display("FAIL bars_no_req: got %b want 0", dr_seen); end
  endtask

  task automatic test_frame();
    int fs_r[$], vs_f[$], vs_r[$], hs_f[$], de_r[$];
    logic p_fs = 1'b0, p_vs = 1'b1, p_hs = 1'b1, p_de = 1'b0;
    int lines = 0;
    mode_med = 2'd0; pix_med = 16'h1234; rst_med = 1'b1;
    for (int k = 0; k < 3700; k++) begin
      tick();
      if (fs_med && !p_fs) fs_r.push_back(k);
      if (!vs_med && p_vs) vs_f.push_back(k);
      if (vs_med && !p_vs) vs_r.push_back(k);
      if (!hs_med && p_hs) hs_f.push_back(k);
      if (de_med && !p_de) de_r.push_back(k);
      p_fs = fs_med; p_vs = vs_med; p_hs = hs_med; p_de = de_med;
    end
    total++;
    if (fs_r.size() < 2 || vs_f.size() < 2 || vs_r.size() < 1 || hs_f.size() < 2) begin
      bad++; $display("FAIL frame_edges: got fs=%0d vs_falls=%0d want >=2", fs_r.size(), vs_f.size());
    end else begin
      foreach (de_r[i]) if (de_r[i] >= fs_r[0] && de_r[i] < fs_r[1]) lines++;
      total++;
      if (fs_r[1] - fs_r[0] !== 1760) begin bad++; $display("FAIL frame_period: got %0d want 1760", fs_r[1] - fs_r[0]); end
      total++;
      if (vs_f[1] - vs_f[0] !== 1760) begin bad++; $display("FAIL vs_period: got %0d want 1760", vs_f[1] - vs_f[0]); end
      total++;
      if (vs_r[0] - vs_f[0] !== 160) begin bad++; $display("FAIL vs_width: got %0d want 160", vs_r[0] - vs_f[0]); end
      total++;
      if (vs_f[0] - fs_r[0] !== 1440) begin bad++; $display("FAIL vs_offset: got %0d want 1440", vs_f[0] - fs_r[0]); end
      total++;
      if (hs_f[1] - hs_f[0] !== 80) begin bad++; $display("FAIL med_hs_period: got %0d want 80", hs_f[1] - hs_f[0]); end
      total++;
      if (lines !== 16) begin bad++; $display("FAIL de_lines: got %0d want 16", lines); end
    end
  endtask

  task automatic test_mode_switch();
    int frame = -1, lines = 0, e0 = 0, e1 = 0, n1 = 0;
    logic p_de = 1'b0;
    logic [15:0] first1 = 16'h0;
    mode_med = 2'd0; fill_med = 16'hF800; pix_med = 16'h1234;
    rst_med = 1'b0; tick(); rst_med = 1'b1;
    for (int k = 0; k < 3720; k++) begin
      tick();
      if (fs_med) begin frame++; lines = 0; if (frame == 1) first1 = vo_med; end
      if (de_med && !p_de) begin
        if (frame == 0 && lines == 8) mode_med = 2'd2;
        lines++;
      end
      if (de_med && frame == 0 && vo_med !== 16'h1234) e0++;
      if (de_med && frame == 1) begin n1++; if (vo_med !== 16'hF800) e1++; end
      p_de = de_med;
    end
    total++;
    if (first1 !== 16'hF800) begin bad++; $display("FAIL switch_first_pixel: got %h want f800", first1); end
    total++;
    if (e0 !== 0) begin bad++; $display("FAIL switch_rest_of_frame: got %0d bad pixels want 0", e0); end
    total++;
    if (e1 !== 0 || n1 !== 1024) begin bad++; $display("FAIL switch_next_frame: got %0d bad of %0d want 0 of 1024", e1, n1); end
  endtask

  task automatic test_reset_mid();
    logic [45:0] g46;
    logic found = 1'b0;
    int fs_at = -1;
    mode_med = 2'd0;
    for (int k = 0; k < 2000 && !found; k++) begin
      tick();
      if (fs_med) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL mid_wait_fs: got timeout want frame_start");
    end else begin
      // Counters now sit at h=74, v=17; outputs lag by four cycles (h=70, inside hsync).
      repeat (1430) tick();
      total++;
      if (hs_med !== 1'b0) begin bad++; $display("FAIL mid_pre_hsync: got %b want 0", hs_med); end
      rst_med = 1'b0;
      tick();
      g46 = {dr_med, hs_med, vs_med, de_med, px_med, py_med, vo_med, fs_med, ls_med};
      total++;
      if (g46 !== {4'b0110, 42'd0}) begin bad++; $display("FAIL mid_reset_outputs: got %h want %h", g46, {4'b0110, 42'd0}); end
      rst_med = 1'b1;
      tick();
      total++;
      if (dr_med !== 1'b1) begin bad++; $display("FAIL mid_restart_req: got %b want 1", dr_med); end
      for (int j = 1; j <= 8 && fs_at < 0; j++) begin
        tick();
        if (fs_med) fs_at = j;
      end
      total++;
      if (fs_at !== 3) begin bad++; $display("FAIL mid_restart_fs: got %0d want 3", fs_at); end
    end
  endtask

  task automatic test_small();
    int hs_f[$], fs_r[$];
    logic p_hs = 1'b1, p_fs = 1'b0;
    int ex = 0, ey = 0, shown = 0;
    logic [23:0] expv;
    rst_sml = 1'b1;
    for (int k = 0; k < 320; k++) begin
      tick();
      if (!hs_sml && p_hs) hs_f.push_back(k);
      if (fs_sml && !p_fs) fs_r.push_back(k);
      p_hs = hs_sml; p_fs = fs_sml;
      if (de_sml) begin
        expv = (ex == 0 || ey == 0) ? 24'hFFFFFF : 24'h0;
        total++;
        if (vo_sml !== expv || px_sml !== ex[3:0] || py_sml !== ey[3:0]) begin
          bad++;
          if (shown < 5) $display("FAIL grid: got x=%0d y=%0d out=%h want x=%0d y=%0d out=%h",
                                  px_sml, py_sml, vo_sml, ex, ey, expv);
          shown++;
        end
        ex++;
        if (ex == 8) begin ex = 0; ey = (ey == 3) ? 0 : ey + 1; end
      end
    end
    total++;
    if (hs_f.size() < 2 || hs_f[1] - hs_f[0] !== 14) begin
      bad++; $display("FAIL small_h_wrap: got %0d want 14", (hs_f.size() < 2) ? -1 : hs_f[1] - hs_f[0]);
    end
    total++;
    if (fs_r.size() < 2 || fs_r[1] - fs_r[0] !== 98) begin
      bad++; $display("FAIL small_v_wrap: got %0d want 98", (fs_r.size() < 2) ? -1 : fs_r[1] - fs_r[0]);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_req_lead3();
    test_color_bars();
    test_frame();
    test_mode_switch();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
